// File: rtl/lieat_exu_com_trapseq_if.sv
// Interface for the trap/return sequencer: commit request, CSR file port and IFU redirect.
// The master modport is the sequencer's view; slave is the view of its environment.
interface lieat_exu_com_trapseq_if #(
    parameter int XLEN = 32
);
    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_cause;
    logic            mret_valid;
    logic            req_ready;
    logic            busy;
    logic            csr_ena;
    logic            csr_write;
    logic            csr_read;
    logic [11:0]     csr_idx;
    logic [XLEN-1:0] csr_wdata;
    logic [11:0]     csr_idx2;
    logic [XLEN-1:0] csr_wdata2;
    logic [XLEN-1:0] csr_rdata;
    logic            flush_valid;
    logic [XLEN-1:0] flush_pc;
    logic            flush_ready;

    modport master (
        input  trap_valid, trap_pc, trap_cause, mret_valid, csr_rdata, flush_ready,
        output req_ready, busy, csr_ena, csr_write, csr_read, csr_idx, csr_wdata,
               csr_idx2, csr_wdata2, flush_valid, flush_pc
    );

    modport slave (
        output trap_valid, trap_pc, trap_cause, mret_valid, csr_rdata, flush_ready,
        input  req_ready, busy, csr_ena, csr_write, csr_read, csr_idx, csr_wdata,
               csr_idx2, csr_wdata2, flush_valid, flush_pc
    );
endinterface

// File: rtl/lieat_exu_com_trapseq.sv
// Trap entry / MRET sequencer: drives a fixed mepc/mcause/mstatus/mtvec CSR
// read-modify-write sequence and then a one-shot redirect to the IFU.
module lieat_exu_com_trapseq #(
    parameter int         XLEN           = 32,
    parameter logic [1:0] MSTATUS_RSTMPP = 2'b11
) (
    input logic                     clk,
    input logic                     rst,
    lieat_exu_com_trapseq_if.master bus
);
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        RD_ST,
        WR_ST,
        RD_TVEC,
        RD_EPC,
        REDIR
    } state_t;

    state_t          state_q, state_d;
    logic            is_trap_q;
    logic [XLEN-1:0] pc_q, cause_q, st_q, target_q;
    logic            accept;
    logic [XLEN-1:0] st_new;
    logic [XLEN-1:0] tvec_base, tvec_off, tvec_target;

    assign accept = (state_q == IDLE) & (bus.trap_valid | bus.mret_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_trap_q <= 1'b0;
            pc_q      <= '0;
            cause_q   <= '0;
            st_q      <= '0;
            target_q  <= '0;
        end else begin
            if (accept) begin
                is_trap_q <= bus.trap_valid;
                pc_q      <= bus.trap_pc;
                cause_q   <= bus.trap_cause;
            end
            if (state_q == RD_ST)
                st_q <= bus.csr_rdata;
            if (state_q == RD_TVEC)
                target_q <= tvec_target;
            else if (state_q == RD_EPC)
                target_q <= {bus.csr_rdata[XLEN-1:1], 1'b0};
        end
    end

    // Vectored mode only applies to interrupts; exceptions always land on the base.
    always_comb begin
        tvec_base   = {bus.csr_rdata[XLEN-1:2], 2'b00};
        tvec_off    = {cause_q[XLEN-3:0], 2'b00};
        tvec_target = tvec_base;
        if (bus.csr_rdata[1:0] == 2'b01 && cause_q[XLEN-1])
            tvec_target = tvec_base + tvec_off;
    end

    always_comb begin
        st_new = st_q;
        if (is_trap_q) begin
            st_new[7]     = st_q[3];
            st_new[3]     = 1'b0;
            st_new[12:11] = MSTATUS_RSTMPP;
        end else begin
            st_new[3]     = st_q[7];
            st_new[7]     = 1'b1;
            st_new[12:11] = 2'b11;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.req_ready   = 1'b0;
        bus.busy        = 1'b1;
        bus.csr_ena     = 1'b0;
        bus.csr_write   = 1'b0;
        bus.csr_read    = 1'b0;
        bus.csr_idx     = 12'h000;
        bus.csr_wdata   = '0;
        bus.csr_idx2    = 12'h000;
        bus.csr_wdata2  = '0;
        bus.flush_valid = 1'b0;
        bus.flush_pc    = '0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.trap_valid)      state_d = T_EPC;
                else if (bus.mret_valid) state_d = RD_ST;
            end
            T_EPC: begin
                bus.csr_ena    = 1'b1;
                bus.csr_write  = 1'b1;
                bus.csr_idx    = CSR_MEPC;
                bus.csr_wdata  = {pc_q[XLEN-1:1], 1'b0};
                bus.csr_idx2   = CSR_MCAUSE;
                bus.csr_wdata2 = cause_q;
                state_d        = RD_ST;
            end
            RD_ST: begin
                bus.csr_ena  = 1'b1;
                bus.csr_read = 1'b1;
                bus.csr_idx  = CSR_MSTATUS;
                state_d      = WR_ST;
            end
            WR_ST: begin
                bus.csr_ena   = 1'b1;
                bus.csr_write = 1'b1;
                bus.csr_idx   = CSR_MSTATUS;
                bus.csr_wdata = st_new;
                state_d       = is_trap_q ? RD_TVEC : RD_EPC;
            end
            RD_TVEC: begin
                bus.csr_ena  = 1'b1;
                bus.csr_read = 1'b1;
                bus.csr_idx  = CSR_MTVEC;
                state_d      = REDIR;
            end
            RD_EPC: begin
                bus.csr_ena  = 1'b1;
                bus.csr_read = 1'b1;
                bus.csr_idx  = CSR_MEPC;
                state_d      = REDIR;
            end
            REDIR: begin
                bus.flush_valid = 1'b1;
                bus.flush_pc    = target_q;
                if (bus.flush_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lieat_exu_com_trapseq.sv
// Directed bench for the trap/return sequencer with a small CSR file model attached.
module tb_lieat_exu_com_trapseq;
    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    logic        preEn;
    logic [11:0] preIdx;
    logic [31:0] preVal;
    logic [31:0] mepcR, mcauseR, mstatusR, mtvecR;

    lieat_exu_com_trapseq_if #(.XLEN(32)) bus ();

    lieat_exu_com_trapseq #(.XLEN(32), .MSTATUS_RSTMPP(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: combinational read, writes on the clock edge.
    always_comb begin
        case (bus.csr_idx)
            12'h300: bus.csr_rdata = mstatusR;
            12'h305: bus.csr_rdata = mtvecR;
            12'h341: bus.csr_rdata = mepcR;
            12'h342: bus.csr_rdata = mcauseR;
            default: bus.csr_rdata = 32'h0;
        endcase
    end

    task automatic csrWr(input logic [11:0] idx, input logic [31:0] val);
        case (idx)
            12'h300: mstatusR = val;
            12'h305: mtvecR   = val;
            12'h341: mepcR    = val;
            12'h342: mcauseR  = val;
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        if (preEn) csrWr(preIdx, preVal);
        else if (bus.csr_ena && bus.csr_write) begin
            csrWr(bus.csr_idx, bus.csr_wdata);
            if (bus.csr_idx2 != 12'h000) csrWr(bus.csr_idx2, bus.csr_wdata2);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setCsr(input logic [11:0] idx, input logic [31:0] val);
        @(negedge clk);
        preEn = 1'b1; preIdx = idx; preVal = val;
        @(negedge clk);
        preEn = 1'b0;
    endtask

    // Issues one request and follows it through the redirect handshake.
    task automatic applyStimulus(input string tag, input logic t, input logic m,
                                 input logic [31:0] pc, input logic [31:0] cause,
                                 input int expLat, input logic [31:0] expPc, input int stall);
        int lat;
        int rdyHigh;
        int csrInRedir;
        @(negedge clk);
        bus.trap_valid = t; bus.mret_valid = m; bus.trap_pc = pc; bus.trap_cause = cause;
        if (stall > 0) bus.flush_ready = 1'b0;
        checkOutput({tag, "_rdy"}, {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.trap_valid = 1'b0; bus.mret_valid = 1'b0;
        lat = 0; rdyHigh = 0; csrInRedir = 0;
        while (!bus.flush_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.req_ready || !bus.busy) rdyHigh++;
        end
        checkOutput({tag, "_lat"}, lat, expLat);
        checkOutput({tag, "_fpc"}, bus.flush_pc, expPc);
        checkOutput({tag, "_rdyLow"}, rdyHigh, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (bus.csr_ena) csrInRedir++;
            checkOutput({tag, "_stallV"}, {31'b0, bus.flush_valid}, 32'd1);
            checkOutput({tag, "_stallPc"}, bus.flush_pc, expPc);
        end
        checkOutput({tag, "_noCsr"}, csrInRedir, 0);
        bus.flush_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_idle"}, {31'b0, bus.req_ready}, 32'd1);
        checkOutput({tag, "_fvOff"}, {31'b0, bus.flush_valid}, 32'd0);
    endtask

    initial begin
        testsRun = 0; testsFailed = 0;
        preEn = 1'b0; preIdx = 12'h0; preVal = 32'h0;
        mepcR = 32'h0; mcauseR = 32'h0; mstatusR = 32'h0; mtvecR = 32'h0;
        bus.trap_valid = 1'b0; bus.mret_valid = 1'b0;
        bus.trap_pc = 32'h0; bus.trap_cause = 32'h0; bus.flush_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_rdy", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("rst_ena", {31'b0, bus.csr_ena}, 32'd0);
        checkOutput("rst_fv", {31'b0, bus.flush_valid}, 32'd0);
        checkOutput("rst_fpc", bus.flush_pc, 32'h0);
        checkOutput("rst_idx", {20'b0, bus.csr_idx}, 32'h0);
        rst = 1'b0;

        // Direct-mode exception.
        setCsr(12'h305, 32'h8000_0100);
        setCsr(12'h300, 32'h0000_0008);
        applyStimulus("direct", 1'b1, 1'b0, 32'h8000_0042, 32'h2, 5, 32'h8000_0100, 0);
        checkOutput("direct_mepc", mepcR, 32'h8000_0042);
        checkOutput("direct_mcause", mcauseR, 32'h2);
        checkOutput("direct_mstatus", mstatusR, 32'h0000_1880);

        // MRET.
        setCsr(12'h341, 32'h8000_0046);
        applyStimulus("mret", 1'b0, 1'b1, 32'h0, 32'h0, 4, 32'h8000_0046, 0);
        checkOutput("mret_mstatus", mstatusR, 32'h0000_1888);

        // Vectored interrupt, other mstatus bits must pass through.
        setCsr(12'h305, 32'h8000_0101);
        setCsr(12'h300, 32'hFFFF_E777);
        applyStimulus("vecIrq", 1'b1, 1'b0, 32'h8000_0010, 32'h8000_0007, 5, 32'h8000_011C, 0);
        checkOutput("vecIrq_mepc", mepcR, 32'h8000_0010);
        checkOutput("vecIrq_mcause", mcauseR, 32'h8000_0007);
        checkOutput("vecIrq_mstatus", mstatusR, 32'hFFFF_FF77);

        // Exception with vectored mtvec still goes to base; odd PC has bit 0 cleared.
        applyStimulus("vecExc", 1'b1, 1'b0, 32'h8000_0203, 32'h3, 5, 32'h8000_0100, 0);
        checkOutput("vecExc_mepc", mepcR, 32'h8000_0202);
        checkOutput("vecExc_mcause", mcauseR, 32'h3);

        // Trap and MRET together: trap wins.
        setCsr(12'h305, 32'h8000_0100);
        applyStimulus("both", 1'b1, 1'b1, 32'h8000_0300, 32'h5, 5, 32'h8000_0100, 0);
        checkOutput("both_mcause", mcauseR, 32'h5);
        checkOutput("both_mepc", mepcR, 32'h8000_0300);

        // MRET with the IFU stalling the redirect.
        applyStimulus("stall", 1'b0, 1'b1, 32'h0, 32'h0, 4, 32'h8000_0300, 3);
        checkOutput("stall_mstatus", mstatusR, 32'hFFFF_FFF7);

        // Reset pulsed while the mstatus write is on the port.
        setCsr(12'h300, 32'h0000_0008);
        @(negedge clk);
        bus.trap_valid = 1'b1; bus.trap_pc = 32'h8000_0500; bus.trap_cause = 32'h4;
        @(posedge clk);
        #1;
        bus.trap_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstmid_wrIdx", {20'b0, bus.csr_idx}, 32'h300);
        checkOutput("rstmid_wr", {31'b0, bus.csr_write}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_ena", {31'b0, bus.csr_ena}, 32'd0);
        checkOutput("rstmid_wdata", bus.csr_wdata, 32'h0);
        @(negedge clk);
        checkOutput("rstmid_mstatus", mstatusR, 32'h0000_0008);
        checkOutput("rstmid_fv", {31'b0, bus.flush_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_rdy", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("rstmid_busy", {31'b0, bus.busy}, 32'd0);

        // Sequencer works normally after the abort.
        applyStimulus("post", 1'b1, 1'b0, 32'h8000_0600, 32'hB, 5, 32'h8000_0100, 0);
        checkOutput("post_mstatus", mstatusR, 32'h0000_1880);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
